// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the address decoder and its default slave.
// Holds the transfer-type and response encodings and the default-slave state type.
package ahb_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;

  localparam logic [1:0] AHB_OKAY  = 2'b00;
  localparam logic [1:0] AHB_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_e;

endpackage

// File: rtl/ahb_def_slv.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR
// response (wait-state ERROR, then ready ERROR).
module ahb_def_slv
  import ahb_pkg::*;
(
  input  logic        hclk_i,
  input  logic        hresetn_i,
  input  logic        active_i,
  output logic [31:0] hrdata_o,
  output logic [1:0]  hresp_o,
  output logic        hready_o
);

  def_state_e state_q, state_d;

  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      state_q <= DEF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = AHB_OKAY;
    hrdata_o = '0;
    unique case (state_q)
      DEF_IDLE: begin
        if (active_i) state_d = DEF_ERR1;
      end
      DEF_ERR1: begin
        // Second error cycle always follows, even if the master drops htrans.
        state_d  = DEF_ERR2;
        hready_o = 1'b0;
        hresp_o  = AHB_ERROR;
      end
      DEF_ERR2: begin
        state_d = active_i ? DEF_ERR1 : DEF_IDLE;
        hresp_o = AHB_ERROR;
      end
      default: begin
        state_d = DEF_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_dec.sv
// AHB-Lite address decoder: priority one-hot decode of haddr, registered
// data-phase select for the response mux, and the integrated default slave.
module ahb_dec
  import ahb_pkg::*;
#(
  parameter int unsigned                 slv_c = 4,
  parameter logic [slv_c-1:0][31:0]      base  = '0,
  parameter logic [slv_c-1:0][31:0]      mask  = '0
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic             hready,
  output logic [slv_c:0]   hsel,
  output logic [slv_c:0]   hsel_ff,
  output logic [31:0]      hrdata_def,
  output logic [1:0]       hresp_def,
  output logic             hready_def
);

  logic [slv_c-1:0] match;
  logic [slv_c:0]   hsel_q, hsel_d;
  logic             found;
  logic             def_active;

  for (genvar gi = 0; gi < slv_c; gi++) begin : g_match
    assign match[gi] = ((haddr & mask[gi]) == (base[gi] & mask[gi]));
  end

  // Lowest matching index wins; no match falls through to the default slave.
  always_comb begin
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(slv_c); i++) begin
      if (match[i] && !found) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
    if (!found) hsel[slv_c] = 1'b1;
  end

  assign hsel_d = hready ? hsel : hsel_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hsel_q <= '0;
    end else begin
      hsel_q <= hsel_d;
    end
  end

  assign hsel_ff    = hsel_q;
  assign def_active = hsel[slv_c] & htrans[1] & hready;

  ahb_def_slv u_def_slv (
    .hclk_i    (hclk),
    .hresetn_i (hresetn),
    .active_i  (def_active),
    .hrdata_o  (hrdata_def),
    .hresp_o   (hresp_def),
    .hready_o  (hready_def)
  );

endmodule

// File: tb/tb_ahb_dec.sv
// Directed self-checking bench for ahb_dec: decode, priority, hsel_ff hold,
// and the default-slave ERROR sequences including back-to-back and reset.
module tb_ahb_dec;
  import ahb_pkg::*;

  localparam int unsigned SLV = 4;
  localparam logic [SLV-1:0][31:0] BASE = {32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [SLV-1:0][31:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hready;
  logic [SLV:0]  hsel;
  logic [SLV:0]  hsel_ff;
  logic [31:0]   hrdata_def;
  logic [1:0]    hresp_def;
  logic          hready_def;

  int total = 0;
  int bad   = 0;

  ahb_dec #(.slv_c(SLV), .base(BASE), .mask(MASK)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .haddr      (haddr),
    .htrans     (htrans),
    .hready     (hready),
    .hsel       (hsel),
    .hsel_ff    (hsel_ff),
    .hrdata_def (hrdata_def),
    .hresp_def  (hresp_def),
    .hready_def (hready_def)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_def(input string tag, input logic rdy, input logic [1:0] resp);
    check({tag, "_rdy"}, {31'd0, hready_def}, {31'd0, rdy});
    check({tag, "_resp"}, {30'd0, hresp_def}, {30'd0, resp});
  endtask

  initial begin
    hresetn = 1'b0;
    haddr   = $urandom;
    htrans  = AHB_NONSEQ;
    hready  = 1'b1;
    #2;
    step(); step(); step();
    check("rst_hsel_ff", {27'd0, hsel_ff}, 32'd0);
    check_def("rst", 1'b1, AHB_OKAY);
    check("rst_rdata", hrdata_def, 32'd0);

    // Mapped decode to slave 1, then hold through wait states
    hresetn = 1'b1;
    haddr   = 32'h1000_0040;
    htrans  = AHB_NONSEQ;
    hready  = 1'b1;
    #1;
    check("map_hsel", {27'd0, hsel}, 32'b00010);
    step();
    check("map_hsel_ff", {27'd0, hsel_ff}, 32'b00010);
    check_def("map", 1'b1, AHB_OKAY);
    hready = 1'b0;
    haddr  = 32'hF000_0000;
    step();
    check("hold1_hsel_ff", {27'd0, hsel_ff}, 32'b00010);
    check_def("hold1", 1'b1, AHB_OKAY);
    step();
    check("hold2_hsel_ff", {27'd0, hsel_ff}, 32'b00010);
    check_def("hold2", 1'b1, AHB_OKAY);

    // Priority and other slaves
    hready = 1'b1;
    htrans = AHB_IDLE;
    haddr  = 32'h0000_0000;
    #1;
    check("prio_hsel", {27'd0, hsel}, 32'b00001);
    haddr = 32'h0100_0000;
    #1;
    check("slv2_hsel", {27'd0, hsel}, 32'b00100);
    haddr = 32'h2345_6789;
    #1;
    check("slv3_hsel", {27'd0, hsel}, 32'b01000);
    step();
    check("slv3_hsel_ff", {27'd0, hsel_ff}, 32'b01000);

    // Single unmapped NONSEQ
    haddr  = 32'hF000_0000;
    htrans = AHB_NONSEQ;
    #1;
    check("unm_hsel", {27'd0, hsel}, 32'b10000);
    step();
    check("unm_hsel_ff", {27'd0, hsel_ff}, 32'b10000);
    check_def("unm_e1", 1'b0, AHB_ERROR);
    hready = 1'b0;
    htrans = AHB_IDLE;
    step();
    check_def("unm_e2", 1'b1, AHB_ERROR);
    hready = 1'b1;
    step();
    check_def("unm_idle", 1'b1, AHB_OKAY);

    // Back-to-back unmapped accesses
    htrans = AHB_NONSEQ;
    step();
    check_def("b2b_e1a", 1'b0, AHB_ERROR);
    hready = 1'b0;
    step();
    check_def("b2b_e2a", 1'b1, AHB_ERROR);
    hready = 1'b1;
    htrans = AHB_SEQ;
    step();
    check_def("b2b_e1b", 1'b0, AHB_ERROR);
    hready = 1'b0;
    htrans = AHB_IDLE;
    step();
    check_def("b2b_e2b", 1'b1, AHB_ERROR);
    hready = 1'b1;
    step();
    check_def("b2b_idle", 1'b1, AHB_OKAY);

    // IDLE and BUSY to unmapped space get zero-wait OKAY
    htrans = AHB_IDLE;
    step();
    check_def("idle_unm", 1'b1, AHB_OKAY);
    htrans = AHB_BUSY;
    step();
    check_def("busy_unm", 1'b1, AHB_OKAY);
    check("busy_hsel_ff", {27'd0, hsel_ff}, 32'b10000);

    // Reset during ERR1
    htrans = AHB_NONSEQ;
    step();
    check_def("rst_e1", 1'b0, AHB_ERROR);
    hresetn = 1'b0;
    hready  = 1'b0;
    step();
    check_def("rst_mid", 1'b1, AHB_OKAY);
    check("rst_mid_hsel_ff", {27'd0, hsel_ff}, 32'd0);
    hresetn = 1'b1;
    hready  = 1'b1;
    htrans  = AHB_IDLE;
    step();
    check_def("rst_after", 1'b1, AHB_OKAY);
    check("rst_after_rdata", hrdata_def, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_dec.md
# ahb_dec

AHB-Lite address decoder with an integrated default slave, feeding the `ahb_mux` response multiplexer. It decodes `haddr` into a one-hot slave select, and registers that select into the data-phase vector `hsel_ff` that the mux consumes. It answers any unmapped access with a compliant two-cycle ERROR response on an extra mux port, index `slv_c`.

## Interface
- `slv_c`, 4: number of mapped slaves.
- `base`, `'{default:'0}`: `[slv_c-1:0][31:0]`, per-slave base address.
- `mask`, `'{default:'0}`: `[slv_c-1:0][31:0]`, per-slave compare mask. A 1 bit means the bit is compared.

Ports:
- `hclk` input 1: bus clock. One clock domain, everything on the rising edge.
- `hresetn` input 1: reset, synchronous, active-low.
- `haddr` input 32: master address-phase address.
- `htrans` input 2: master transfer type.
- `hready` input 1: bus ready, the `ahb_mux` `hready` output fed back.
- `hsel` output `slv_c+1`: combinational address-phase select, one-hot. Bit `slv_c` selects the default slave.
- `hsel_ff` output `slv_c+1`: registered data-phase select, wired to `ahb_mux` `hsel_ff`.
- `hrdata_def` output 32: default-slave read data, to mux port `slv_c`.
- `hresp_def` output 2: default-slave response, to mux port `slv_c`.
- `hready_def` output 1: default-slave ready, to mux port `slv_c`.

## Operation
- Match rule: slave `i` matches when `(haddr & mask[i]) == (base[i] & mask[i])`.
- Priority: lowest matching index wins, so `hsel` is always exactly one-hot.
- No match: `hsel[slv_c]=1`.
- `hsel` is a pure address decode, independent of `htrans`. Slaves qualify it with `htrans`.
- `hsel_ff` loads `hsel` on every edge where `hready=1`, and holds while `hready=0`.
- Default-slave FSM (states `IDLE`, `ERR1`, `ERR2`):
  - Active condition: `hsel[slv_c] & htrans[1] & hready` (NONSEQ or SEQ).
  - `IDLE`: active -> `ERR1`, else stay.
  - `ERR1`: always -> `ERR2`.
  - `ERR2`: active -> `ERR1` (back-to-back unmapped accesses), else -> `IDLE`.
- Default-slave outputs by state:
  - `IDLE`: `hready_def=1`, `hresp_def=2'b00` (OKAY).
  - `ERR1`: `hready_def=0`, `hresp_def=2'b01` (ERROR).
  - `ERR2`: `hready_def=1`, `hresp_def=2'b01`.
- `hrdata_def` is always `'0`.
- IDLE or BUSY transfers to unmapped space get a zero-wait OKAY.
- The master changing `htrans` to IDLE during `ERR1` does not cancel the error. Both cycles always complete.

## Timing
- Reset values (`hresetn=0` at an edge): `hsel_ff='0`, state `IDLE`, `hready_def=1`, `hresp_def=2'b00`, `hrdata_def='0`.
- Reset mid-error sequence: next cycle is `IDLE`/OKAY, with no residual ERROR cycle.
- `hsel`: zero latency (combinational from `haddr`).
- `hsel_ff`: one cycle after the accepting `hready` edge.
- Default-slave outputs: registered state, so they are valid one cycle after the accepting edge.
- ERROR occupies exactly two data-phase cycles: `hready_def` 0 then 1, with `hresp_def=01` on both.
- Slave-inserted wait states (`hready=0`) freeze `hsel_ff`, and the FSM cannot enter `ERR1`.

## Structure
- `ahb_pkg` holds the shared definitions:
  - `htrans` constants `AHB_IDLE=2'b00`, `AHB_BUSY=2'b01`, `AHB_NONSEQ=2'b10`, `AHB_SEQ=2'b11`;
  - `hresp` constants `AHB_OKAY=2'b00`, `AHB_ERROR=2'b01`;
  - the FSM state enum.
- Sub-module `ahb_def_slv` contains the FSM and its outputs.
- `ahb_dec` contains the decode logic and the `hsel_ff` register, and instantiates `ahb_def_slv`.

## Test plan
- **Reset:** hold `hresetn=0` for 3 cycles with a random `haddr` -> `hsel_ff=0`, `hready_def=1`, `hresp_def=00`.
- **Mapped decode and hold:**
  - Setup: `slv_c=4`, `base[1]=32'h1000_0000`, `mask[1]=32'hF000_0000`.
  - Stimulus: `haddr=32'h1000_0040`, NONSEQ, `hready=1`.
  - Required: `hsel=5'b00010` the same cycle, and `hsel_ff=5'b00010` the next cycle.
  - Then drive `hready=0` for 2 cycles -> `hsel_ff` unchanged.
- **Overlap priority:** slaves 0 and 2 both match `32'h0` -> `hsel=5'b00001`.
- **Unmapped NONSEQ:** `haddr=32'hF000_0000` -> `hsel[4]=1`. The next two cycles give `hready_def`/`hresp_def` = 0/01 then 1/01, followed by `IDLE`/OKAY.
- **Back-to-back unmapped accesses:** NONSEQ unmapped, issued again on the `ERR2` edge -> the sequence 0/01, 1/01, 0/01, 1/01 with no OKAY gap.
- **Non-active and reset cases:**
  - IDLE to unmapped space -> `hready_def=1`, `hresp_def=00`.
  - Reset asserted during `ERR1` -> the next cycle is OKAY, ready 1.
